// File: rtl/game_pkg.sv
// Shared game definitions: opcodes, directions, pages, key codes and the
// layout of the 16-bit player instruction word {op[3:0], operand[7:0], 4'b0}.
package game_pkg;
    // Player instruction opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_HPY = 4'h1;
    localparam logic [3:0] OP_DPY = 4'h2;
    localparam logic [3:0] OP_IDG = 4'h3;
    localparam logic [3:0] OP_SDG = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_SHP = 4'h6;

    // Movement directions
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // Game pages
    localparam logic [2:0] PG_NULL   = 3'd0;
    localparam logic [2:0] PG_MENU   = 3'd1;
    localparam logic [2:0] PG_START  = 3'd2;
    localparam logic [2:0] PG_DODGE  = 3'd3;
    localparam logic [2:0] PG_ATTACK = 3'd4;
    localparam logic [2:0] PG_ACTION = 3'd5;

    // Keyboard scan codes used by the movement path
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    // Instruction field positions
    localparam int INSTR_OP_MSB  = 15;
    localparam int INSTR_OP_LSB  = 12;
    localparam int INSTR_OPD_MSB = 11;
    localparam int INSTR_OPD_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    function automatic logic [15:0] mk_instr(input logic [3:0] op, input logic [7:0] opd);
        return {op, opd, 4'b0000};
    endfunction
endpackage

// File: rtl/dmg_accumulator.sv
// 8-bit saturating damage accumulator.
// Ports: clk, reset (sync, active-high), clear (flush), add/amt (accumulate),
//        take (consume current value), acc (current value), pending (non-zero
//        damage waiting to be issued).
// A take coinciding with an add hands out the old value and reloads from amt.
module dmg_accumulator (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] amt,
    input  logic       take,
    output logic [7:0] acc,
    output logic       pending
);
    logic [7:0] acc_q, acc_d;
    logic       pend_q, pend_d;
    logic [8:0] sum;

    assign sum = {1'b0, acc_q} + {1'b0, amt};

    always_comb begin
        acc_d  = acc_q;
        pend_d = pend_q;
        if (clear) begin
            acc_d  = 8'h00;
            pend_d = 1'b0;
        end else if (take && add) begin
            acc_d  = amt;
            pend_d = 1'b1;
        end else if (take) begin
            acc_d  = 8'h00;
            pend_d = 1'b0;
        end else if (add) begin
            acc_d  = sum[8] ? 8'hFF : sum[7:0];
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= 8'h00;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end

    assign acc     = acc_q;
    assign pending = pend_q;
endmodule

// File: rtl/player_instr_arbiter.sv
// Arbitrates the player instruction bus between damage, heal and movement.
// Ports: clk, reset (sync, active-high), enable (page == DODGE), is_death
//        (flush), dmg_req/dmg_amt, heal_req, move_req/move_dir, instr/
//        instr_valid/instr_ready (valid/ready handshake), dmg_pending.
// Requests are latched on one edge and may issue on the next; priority is
// DPY > HPY > MOV, and MOV is rate-limited to one per MOVE_DIV cycles.
module player_instr_arbiter
    import game_pkg::*;
#(
    parameter int         MOVE_DIV = 4,
    parameter logic [7:0] HEAL_AMT = 8'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        is_death,
    input  logic        dmg_req,
    input  logic [7:0]  dmg_amt,
    input  logic        heal_req,
    input  logic        move_req,
    input  logic [1:0]  move_dir,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        dmg_pending
);
    localparam int TW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    arb_state_e    state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic          heal_q, heal_d;
    logic          move_q, move_d;
    logic [1:0]    dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;

    logic       transfer, slot;
    logic       iss_dpy, iss_hpy, iss_mov;
    logic [7:0] acc;

    dmg_accumulator u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (is_death),
        .add     (dmg_req && (dmg_amt != 8'h00) && !is_death),
        .amt     (dmg_amt),
        .take    (iss_dpy),
        .acc     (acc),
        .pending (dmg_pending)
    );

    assign transfer = (state_q == ST_HOLD) && instr_ready;
    assign slot     = ((state_q == ST_IDLE) || transfer) && enable && !is_death;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= 16'h0000;
            heal_q  <= 1'b0;
            move_q  <= 1'b0;
            dir_q   <= 2'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            heal_q  <= heal_d;
            move_q  <= move_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        iss_dpy = 1'b0;
        iss_hpy = 1'b0;
        iss_mov = 1'b0;
        if (is_death) begin
            state_d = ST_IDLE;
            instr_d = 16'h0000;
        end else if (slot) begin
            if (dmg_pending) begin
                iss_dpy = 1'b1;
                state_d = ST_HOLD;
                instr_d = mk_instr(OP_DPY, acc);
            end else if (heal_q) begin
                iss_hpy = 1'b1;
                state_d = ST_HOLD;
                instr_d = mk_instr(OP_HPY, HEAL_AMT);
            end else if (move_q && (timer_q == '0)) begin
                iss_mov = 1'b1;
                state_d = ST_HOLD;
                instr_d = mk_instr(OP_MOV, {6'b0, dir_q});
            end else begin
                state_d = ST_IDLE;
                instr_d = 16'h0000;
            end
        end else if (transfer) begin
            // Accepted while disabled: nothing may follow it
            state_d = ST_IDLE;
            instr_d = 16'h0000;
        end

        // A new request in the issue cycle wins over the clear
        heal_d = heal_q;
        if (is_death)       heal_d = 1'b0;
        else if (heal_req)  heal_d = 1'b1;
        else if (iss_hpy)   heal_d = 1'b0;

        move_d = move_q;
        dir_d  = dir_q;
        if (is_death || !enable) begin
            move_d = 1'b0;
        end else if (move_req) begin
            move_d = 1'b1;
            dir_d  = move_dir;
        end else if (iss_mov) begin
            move_d = 1'b0;
        end

        timer_d = timer_q;
        if (is_death)              timer_d = '0;
        else if (iss_mov)          timer_d = TW'(MOVE_DIV - 1);
        else if (timer_q != '0)    timer_d = timer_q - 1'b1;
    end

    // Outputs
    always_comb begin
        instr_valid = (state_q == ST_HOLD);
        instr       = (state_q == ST_HOLD) ? instr_q : 16'h0000;
    end
endmodule

// File: tb/tb_player_instr_arbiter.sv
module tb_player_instr_arbiter;
    logic        clk = 1'b0;
    logic        reset, enable, is_death, dmg_req, heal_req, move_req, instr_ready;
    logic [7:0]  dmg_amt;
    logic [1:0]  move_dir;
    logic [15:0] instr;
    logic        instr_valid, dmg_pending;

    int errors = 0;
    int checks = 0;

    player_instr_arbiter #(.MOVE_DIV(4), .HEAL_AMT(8'd10)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .is_death    (is_death),
        .dmg_req     (dmg_req),
        .dmg_amt     (dmg_amt),
        .heal_req    (heal_req),
        .move_req    (move_req),
        .move_dir    (move_dir),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .dmg_pending (dmg_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; is_death = 1'b0; dmg_req = 1'b0; dmg_amt = 8'h00;
        heal_req = 1'b0; move_req = 1'b0; move_dir = 2'd0; instr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (dmg_pending !== 1'b0) begin errors++; $display("FAIL reset_dmgp got %b want 0", dmg_pending); end
        // Reset while holding an instruction drops it at the next edge
        enable = 1'b1; dmg_req = 1'b1; dmg_amt = 8'd5; tick(); dmg_req = 1'b0; tick();
        checks++; if (instr !== 16'h2050 || instr_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_hold got %h/%b want 2050/1", instr, instr_valid); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (instr !== 16'h0000 || instr_valid !== 1'b0 || dmg_pending !== 1'b0) begin
            errors++; $display("FAIL reset_mid_hold got %h/%b/%b want 0000/0/0", instr, instr_valid, dmg_pending); end
    endtask

    task automatic test_move();
        do_reset();
        enable = 1'b1; instr_ready = 1'b1; move_req = 1'b1; move_dir = 2'd3;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL move_latency got valid %b want 0", instr_valid); end
        tick();
        checks++; if (instr !== 16'h5030 || instr_valid !== 1'b1) begin errors++; $display("FAIL move_first got %h/%b want 5030/1", instr, instr_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL move_gap%0d got valid %b want 0", i, instr_valid); end
        end
        tick();
        checks++; if (instr !== 16'h5030 || instr_valid !== 1'b1) begin errors++; $display("FAIL move_second got %h/%b want 5030/1", instr, instr_valid); end
        move_req = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        enable = 1'b1; instr_ready = 1'b1;
        dmg_req = 1'b1; dmg_amt = 8'd7; heal_req = 1'b1;
        tick();
        dmg_req = 1'b0; heal_req = 1'b0;
        checks++; if (dmg_pending !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL prio_capture got dmgp %b valid %b want 1/0", dmg_pending, instr_valid); end
        tick();
        checks++; if (instr !== 16'h2070 || instr_valid !== 1'b1) begin errors++; $display("FAIL prio_dpy got %h/%b want 2070/1", instr, instr_valid); end
        tick();
        checks++; if (instr !== 16'h10A0 || instr_valid !== 1'b1) begin errors++; $display("FAIL prio_hpy got %h/%b want 10A0/1", instr, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || dmg_pending !== 1'b0) begin errors++; $display("FAIL prio_done got valid %b dmgp %b want 0/0", instr_valid, dmg_pending); end
    endtask

    task automatic test_saturate();
        do_reset();
        enable = 1'b1; instr_ready = 1'b0; move_req = 1'b1; move_dir = 2'd1;
        tick(); move_req = 1'b0; tick();
        checks++; if (instr !== 16'h5010) begin errors++; $display("FAIL sat_mov got %h want 5010", instr); end
        dmg_req = 1'b1; dmg_amt = 8'd200; tick();
        dmg_amt = 8'd50; tick();
        dmg_amt = 8'd30; tick();
        dmg_req = 1'b0;
        checks++; if (instr !== 16'h5010 || instr_valid !== 1'b1 || dmg_pending !== 1'b1) begin
            errors++; $display("FAIL sat_hold got %h/%b dmgp %b want 5010/1/1", instr, instr_valid, dmg_pending); end
        instr_ready = 1'b1; tick();
        checks++; if (instr !== 16'h2FF0 || instr_valid !== 1'b1) begin errors++; $display("FAIL sat_dpy got %h/%b want 2FF0/1", instr, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0 || dmg_pending !== 1'b0) begin errors++; $display("FAIL sat_done got valid %b dmgp %b want 0/0", instr_valid, dmg_pending); end
    endtask

    task automatic test_hold_stall();
        do_reset();
        enable = 1'b1; instr_ready = 1'b0; dmg_req = 1'b1; dmg_amt = 8'd5;
        tick(); dmg_req = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (instr !== 16'h2050 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall%0d got %h/%b want 2050/1", i, instr, instr_valid); end
        end
        instr_ready = 1'b1; tick();
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000) begin errors++; $display("FAIL stall_xfer got %h/%b want 0000/0", instr, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_single got valid %b want 0", instr_valid); end
    endtask

    task automatic test_death();
        do_reset();
        enable = 1'b1; instr_ready = 1'b0; dmg_req = 1'b1; dmg_amt = 8'd5;
        tick(); dmg_req = 1'b0; tick();
        heal_req = 1'b1; tick(); heal_req = 1'b0;
        dmg_req = 1'b1; dmg_amt = 8'd9; tick(); dmg_req = 1'b0;
        checks++; if (dmg_pending !== 1'b1 || instr !== 16'h2050) begin errors++; $display("FAIL death_pre got %h dmgp %b want 2050/1", instr, dmg_pending); end
        is_death = 1'b1; heal_req = 1'b1; tick(); is_death = 1'b0; heal_req = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || dmg_pending !== 1'b0) begin
            errors++; $display("FAIL death_flush got %h/%b dmgp %b want 0000/0/0", instr, instr_valid, dmg_pending); end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL death_quiet%0d got valid %b want 0", i, instr_valid); end
        end
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b1; instr_ready = 1'b0; dmg_req = 1'b1; dmg_amt = 8'd3;
        tick(); dmg_req = 1'b0; tick();
        checks++; if (instr !== 16'h2030) begin errors++; $display("FAIL en_hold got %h want 2030", instr); end
        heal_req = 1'b1; dmg_req = 1'b1; dmg_amt = 8'd4; move_req = 1'b1; move_dir = 2'd2;
        tick();
        heal_req = 1'b0; dmg_req = 1'b0; move_req = 1'b0;
        enable = 1'b0; instr_ready = 1'b1; tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL en_xfer got valid %b want 0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b0 || dmg_pending !== 1'b1) begin
                errors++; $display("FAIL en_off%0d got valid %b dmgp %b want 0/1", i, instr_valid, dmg_pending); end
        end
        enable = 1'b1; tick();
        checks++; if (instr !== 16'h2040 || instr_valid !== 1'b1) begin errors++; $display("FAIL en_dpy got %h/%b want 2040/1", instr, instr_valid); end
        tick();
        checks++; if (instr !== 16'h10A0 || instr_valid !== 1'b1) begin errors++; $display("FAIL en_hpy got %h/%b want 10A0/1", instr, instr_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL en_nomov%0d got %h/%b want 0000/0", i, instr, instr_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_priority();
        test_saturate();
        test_hold_stall();
        test_death();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
